// File: rtl/regs_if.sv
// Register-file bus: decode read ports, execute write port, debug read port and
// the committed-write counter, grouped so the file is one connection.
interface regs_if;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic [AW-1:0] reg1_raddr_i;
  logic [AW-1:0] reg2_raddr_i;
  logic [DW-1:0] reg1_rdata_o;
  logic [DW-1:0] reg2_rdata_o;
  logic [AW-1:0] reg_waddr_i;
  logic [DW-1:0] reg_wdata_i;
  logic          reg_wen_i;
  logic [AW-1:0] dbg_raddr_i;
  logic [DW-1:0] dbg_rdata_o;
  logic [DW-1:0] wr_cnt_o;

  // Register file side
  modport slave (
    input  reg1_raddr_i, reg2_raddr_i, reg_waddr_i, reg_wdata_i, reg_wen_i,
           dbg_raddr_i,
    output reg1_rdata_o, reg2_rdata_o, dbg_rdata_o, wr_cnt_o
  );

  // Pipeline / debugger side
  modport master (
    output reg1_raddr_i, reg2_raddr_i, reg_waddr_i, reg_wdata_i, reg_wen_i,
           dbg_raddr_i,
    input  reg1_rdata_o, reg2_rdata_o, dbg_rdata_o, wr_cnt_o
  );
endinterface

// File: rtl/regs.sv
// regs: 31 x 32-bit integer register file (x0 hardwired to zero), two
// combinational read ports, one write port, a non-forwarding debug read port
// and a committed-write counter.
// Optional feature: define REGS_BYPASS_EN to forward the in-flight write data
// to read ports 1 and 2 when their address matches the write address.
module regs (
  input  logic         clk,
  input  logic         rst,
  regs_if.slave        bus
);
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned NREG = 32;

  logic [DW-1:0] r_mem [1:NREG-1];
  logic [DW-1:0] r_wr_cnt;
  logic          w_commit;
  logic [DW-1:0] w_rd1;
  logic [DW-1:0] w_rd2;
  logic [DW-1:0] w_dbg;

  // A write only lands outside reset and never on x0
  assign w_commit = bus.reg_wen_i & ~rst & (bus.reg_waddr_i != AW'(0));

  // Array lookup with x0 reading as zero
  function automatic logic [DW-1:0] arr_read(input logic [AW-1:0] addr);
    if (addr == AW'(0)) return DW'(0);
    return r_mem[addr];
  endfunction

  // Storage: clear every register on reset, otherwise commit the write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < NREG; i++) r_mem[i] <= DW'(0);
    end else if (w_commit) begin
      r_mem[bus.reg_waddr_i] <= bus.reg_wdata_i;
    end
  end

  // Committed-write counter, wraps naturally
  always_ff @(posedge clk) begin
    if (rst) r_wr_cnt <= DW'(0);
    else if (w_commit) r_wr_cnt <= r_wr_cnt + DW'(1);
  end

  // Read ports; the optional bypass picks up the write in flight
  always_comb begin
    w_rd1 = arr_read(bus.reg1_raddr_i);
    w_rd2 = arr_read(bus.reg2_raddr_i);
    w_dbg = arr_read(bus.dbg_raddr_i);
`ifdef REGS_BYPASS_EN
    if (w_commit && (bus.reg_waddr_i == bus.reg1_raddr_i)) w_rd1 = bus.reg_wdata_i;
    if (w_commit && (bus.reg_waddr_i == bus.reg2_raddr_i)) w_rd2 = bus.reg_wdata_i;
`endif
  end

  assign bus.reg1_rdata_o = w_rd1;
  assign bus.reg2_rdata_o = w_rd2;
  assign bus.dbg_rdata_o  = w_dbg;
  assign bus.wr_cnt_o     = r_wr_cnt;
endmodule

// File: tb/tb_regs.sv
// Scoreboard bench for regs: a driver issues one operation per cycle and
// pushes the expected read/counter values; a monitor pops and compares them
// mid-cycle. Directed scenarios first, then randomized traffic.
module tb_regs;
  logic clk;
  logic rst;

  regs_if u_bus ();

  regs u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] dbg;
    logic [31:0] cnt;
    int          tag;
  } exp_t;

  exp_t        sb_q[$];
  int          checks;
  int          errors;

  // Reference state: plain array of architectural registers plus a counter
  logic [31:0] m_reg [32];
  logic [31:0] m_cnt;
  bit          m_valid;

`ifdef REGS_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  function automatic logic [31:0] m_read(input logic [4:0] a, input bit fwd,
                                         input bit wr, input logic [4:0] wa,
                                         input logic [31:0] wd);
    if (a == 5'd0) return 32'h0;
    if (fwd && wr && wa == a) return wd;
    return m_reg[a];
  endfunction

  // One cycle of stimulus: drive, predict, then advance the model
  task automatic cyc(input bit r, input bit wen, input logic [4:0] wa,
                     input logic [31:0] wd, input logic [4:0] a1,
                     input logic [4:0] a2, input logic [4:0] ad, input int tag);
    exp_t e;
    bit   wr;
    @(posedge clk);
    #1;
    rst                = r;
    u_bus.reg_wen_i    = wen;
    u_bus.reg_waddr_i  = wa;
    u_bus.reg_wdata_i  = wd;
    u_bus.reg1_raddr_i = a1;
    u_bus.reg2_raddr_i = a2;
    u_bus.dbg_raddr_i  = ad;
    wr = wen && !r && (wa != 5'd0);
    if (m_valid) begin
      e.rd1 = m_read(a1, BYPASS, wr, wa, wd);
      e.rd2 = m_read(a2, BYPASS, wr, wa, wd);
      e.dbg = m_read(ad, 1'b0, wr, wa, wd);
      e.cnt = m_cnt;
      e.tag = tag;
      sb_q.push_back(e);
    end
    if (r) begin
      for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
      m_cnt   = 32'h0;
      m_valid = 1'b1;
    end else if (wr) begin
      m_reg[wa] = wd;
      m_cnt     = m_cnt + 32'd1;
    end
  endtask

  // Jump the write counter to its wrap point between two idle edges
  task automatic force_cnt_max();
    @(posedge clk);
    #1;
    rst             = 1'b0;
    u_bus.reg_wen_i = 1'b0;
    force u_dut.r_wr_cnt = 32'hFFFF_FFFF;
    #1;
    release u_dut.r_wr_cnt;
    m_cnt = 32'hFFFF_FFFF;
  endtask

  // Monitor: outputs are combinational, so compare mid-cycle
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      exp_t e;
      e = sb_q.pop_front();
      checks = checks + 4;
      if (u_bus.reg1_rdata_o !== e.rd1) begin
        errors = errors + 1;
        $display("FAIL rd1 tag=%0d got=%h exp=%h", e.tag, u_bus.reg1_rdata_o, e.rd1);
      end
      if (u_bus.reg2_rdata_o !== e.rd2) begin
        errors = errors + 1;
        $display("FAIL rd2 tag=%0d got=%h exp=%h", e.tag, u_bus.reg2_rdata_o, e.rd2);
      end
      if (u_bus.dbg_rdata_o !== e.dbg) begin
        errors = errors + 1;
        $display("FAIL dbg tag=%0d got=%h exp=%h", e.tag, u_bus.dbg_rdata_o, e.dbg);
      end
      if (u_bus.wr_cnt_o !== e.cnt) begin
        errors = errors + 1;
        $display("FAIL wr_cnt tag=%0d got=%h exp=%h", e.tag, u_bus.wr_cnt_o, e.cnt);
      end
    end
  end

  initial begin
    checks  = 0;
    errors  = 0;
    m_cnt   = 32'h0;
    m_valid = 1'b0;
    for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
    rst                = 1'b1;
    u_bus.reg_wen_i    = 1'b0;
    u_bus.reg_waddr_i  = 5'd0;
    u_bus.reg_wdata_i  = 32'h0;
    u_bus.reg1_raddr_i = 5'd0;
    u_bus.reg2_raddr_i = 5'd0;
    u_bus.dbg_raddr_i  = 5'd0;

    // Reset, held two cycles
    cyc(1, 0, 5'd0, 32'h0, 5'd1, 5'd31, 5'd5, 1);
    cyc(1, 1, 5'd4, 32'h1111_1111, 5'd4, 5'd0, 5'd4, 2);
    // Reset clear of a preloaded register
    cyc(0, 1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd5, 5'd5, 10);
    cyc(0, 0, 5'd0, 32'h0, 5'd5, 5'd5, 5'd5, 11);
    cyc(1, 0, 5'd0, 32'h0, 5'd5, 5'd5, 5'd5, 12);
    cyc(0, 0, 5'd0, 32'h0, 5'd5, 5'd5, 5'd5, 13);
    // Write then read on both ports
    cyc(0, 1, 5'd3, 32'h1234_5678, 5'd3, 5'd3, 5'd3, 20);
    cyc(0, 0, 5'd0, 32'h0, 5'd3, 5'd3, 5'd3, 21);
    // x0 protection
    cyc(0, 1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0, 30);
    cyc(0, 0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0, 31);
    // Bypass scenario on x7; port 2 away from the write address
    cyc(0, 1, 5'd7, 32'h1, 5'd0, 5'd0, 5'd0, 40);
    cyc(0, 1, 5'd7, 32'h2, 5'd7, 5'd3, 5'd7, 41);
    cyc(0, 0, 5'd0, 32'h0, 5'd7, 5'd7, 5'd7, 42);
    // Write ignored when enable is low
    cyc(0, 0, 5'd7, 32'hBAD0_BAD0, 5'd7, 5'd7, 5'd7, 45);
    cyc(0, 0, 5'd0, 32'h0, 5'd7, 5'd7, 5'd7, 46);
    // Reset collides with a write
    cyc(1, 1, 5'd9, 32'hA5A5_A5A5, 5'd9, 5'd9, 5'd9, 50);
    cyc(0, 0, 5'd0, 32'h0, 5'd9, 5'd9, 5'd9, 51);
    // Counter wrap
    force_cnt_max();
    cyc(0, 1, 5'd12, 32'hCAFE_F00D, 5'd12, 5'd12, 5'd12, 60);
    cyc(0, 0, 5'd0, 32'h0, 5'd12, 5'd12, 5'd12, 61);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      bit          r;
      bit          wen;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [4:0]  a1;
      logic [4:0]  a2;
      logic [4:0]  ad;
      r   = ($urandom_range(0, 49) == 0);
      wen = ($urandom_range(0, 1) == 1);
      wa  = 5'($urandom_range(0, 31));
      wd  = $urandom;
      a1  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      a2  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      ad  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      cyc(r, wen, wa, wd, a1, a2, ad, 1000 + n);
    end
    cyc(0, 0, 5'd0, 32'h0, 5'd1, 5'd2, 5'd3, 9999);

    // Drain the scoreboard within a bounded number of cycles
    repeat (4) @(posedge clk);
    checks = checks + 1;
    if (sb_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain pending=%0d exp=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regs.md
REGS -- requirements
Module: regs

Interface
REQ-001 The block SHALL have exactly one clock and one reset: the reset is synchronous and active-high, named rst, sampled on the rising edge of clk.
REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- reg1_raddr_i  in  5  read port 1 address (rs1, from decode).
- reg2_raddr_i  in  5  read port 2 address (rs2, from decode).
- reg1_rdata_o  out  32  read port 1 data.
- reg2_rdata_o  out  32  read port 2 data.
- reg_waddr_i  in  5  write address (rd_addr from execute).
- reg_wdata_i  in  32  write data (rd_data from execute).
- reg_wen_i  in  1  write enable (rd_wen from execute).
- dbg_raddr_i  in  5  debug read address.
- dbg_rdata_o  out  32  debug read data; combinational, never forwarded.
- wr_cnt_o  out  32  count of committed writes to x1..x31.

Function
REQ-003 Storage SHALL be 31 x 32-bit registers (x1..x31); x0 SHALL have no storage and always read 32'h0.
REQ-004 A write SHALL commit on the rising edge of clk when reg_wen_i=1, rst=0 and reg_waddr_i!=0; the new value SHALL be visible through the array from the next cycle.
REQ-005 A write with reg_waddr_i=0 SHALL be discarded: no state change, wr_cnt_o not incremented.
REQ-006 Read ports SHALL be combinational (zero-cycle latency): each output reflects the array contents for its address in the same cycle.
REQ-007 Both read ports SHALL serve the same address simultaneously with identical data.
REQ-008 wr_cnt_o SHALL increment by 1 on each committed write (REQ-004) and wrap from 32'hFFFF_FFFF to 32'h0.
REQ-009 A write coinciding with reset SHALL be dropped; reset wins.
REQ-010 reg_wdata_i and reg_waddr_i SHALL be ignored when reg_wen_i=0.

Reset
REQ-011 On a clock edge with rst=1, all of x1..x31 SHALL become 32'h0 within that single cycle.
REQ-012 On a clock edge with rst=1, wr_cnt_o SHALL become 32'h0.
REQ-013 Holding rst=1 for multiple cycles SHALL keep all state at zero.
REQ-014 Reads during reset SHALL return the current (zeroed after the first reset edge) array contents; no X SHALL appear on any output after the first reset edge.

Configuration
REQ-015 Macro REGS_BYPASS_EN SHALL control write-to-read forwarding.
REQ-016 With REGS_BYPASS_EN defined: when reg_wen_i=1, rst=0, reg_waddr_i!=0 and reg_waddr_i equals a read port's address, that port SHALL output reg_wdata_i in the same cycle.
REQ-017 Without REGS_BYPASS_EN: read ports SHALL return array contents only; the written value appears the cycle after the write.
REQ-018 In both configurations, address 0 SHALL read 32'h0 even when being "written".
REQ-019 The debug port SHALL never forward in either configuration.

Verification
REQ-020 Reset clear: preload x5=32'hDEAD_BEEF, assert rst for 1 cycle -> reg1_rdata_o(addr 5)=0, wr_cnt_o=0.
REQ-021 Write/read: write x3=32'h1234_5678; read both ports at addr 3 the next cycle -> both equal 32'h1234_5678, wr_cnt_o=1.
REQ-022 x0 protection: write x0=32'hFFFF_FFFF -> read addr 0 returns 0 on all ports, wr_cnt_o unchanged.
REQ-023 Bypass: x7=32'h1, same cycle write x7=32'h2 with reg1_raddr_i=7 -> reg1_rdata_o=32'h2 with REGS_BYPASS_EN, 32'h1 without; next cycle 32'h2 in both; dbg_rdata_o(addr 7) stays 32'h1 during the write cycle.
REQ-024 Reset collision: rst=1 and write x9=32'hA5A5_A5A5 in the same cycle -> x9 reads 0 afterwards, wr_cnt_o=0.
REQ-025 Counter wrap: force wr_cnt_o to 32'hFFFF_FFFF and commit one write -> wr_cnt_o=32'h0.
